ripple_count_capture: RTL and testbench

Clean-domain capture stage sitting directly downstream of the asynchronous ripple counter. Samples the counter's ripple-settling output into the `clk` domain and waits for the value to be stable. Presents a glitch-free snapshot plus the wrap-aware delta since the previous snapshot over a valid/ready handshake. Guards against a counter that never settles with a bounded timeout.

---
 rtl/ripple_capture_pkg.sv | 16 +
 rtl/ripple_sync.sv | 30 +++
 rtl/ripple_count_capture.sv | 108 ++++++++++
 tb/tb_ripple_count_capture.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ripple_capture_pkg.sv
// Shared types and constants for the ripple counter capture stage.
package ripple_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Wide enough for STABLE up to 15 and TIMEOUT up to 255.
  localparam int STAB_W = 4;
  localparam int WAIT_W = 8;

endpackage

// File: rtl/ripple_sync.sv
// Per-bit multi-flop synchronizer bringing the ripple counter into the clk domain.
module ripple_sync
  import ripple_capture_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], d[gi]};
        end
      end

      assign q[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/ripple_count_capture.sv
// Captures a settled ripple counter value and presents it with the wrap-aware
// delta since the previous capture over a valid/ready handshake.
module ripple_count_capture
  import ripple_capture_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int STABLE  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [SIZE-1:0] cnt_in,
  input  logic            req,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_cnt,
  output logic [SIZE-1:0] out_delta,
  output logic            out_timeout
);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [SIZE-1:0]   sync_q;
  logic [SIZE-1:0]   prev_q;
  logic [SIZE-1:0]   last_cnt;
  logic [STAB_W-1:0] stab_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              stable;
  logic              capture;

  ripple_sync #(
    .WIDTH (SIZE)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (cnt_in),
    .q    (sync_q)
  );

  assign stable  = (stab_cnt == STAB_MAX);
  // Stability wins over timeout; out_timeout only records a forced capture.
  assign capture = (state_reg == SETTLE) && (stable || (wait_cnt == WAIT_MAX));

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (req) state_next = SETTLE;
      SETTLE:  if (capture) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Stability tracking runs in every state so a steady input is ready at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q   <= '0;
      stab_cnt <= '0;
    end else begin
      prev_q <= sync_q;
      if (sync_q != prev_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if ((state_reg == IDLE) && req) begin
      wait_cnt <= '0;
    end else if (state_reg == SETTLE) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt     <= '0;
      out_delta   <= '0;
      out_timeout <= 1'b0;
      last_cnt    <= '0;
    end else if (capture) begin
      out_cnt     <= sync_q;
      out_delta   <= sync_q - last_cnt;
      out_timeout <= !stable;
      last_cnt    <= sync_q;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == HOLD);

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture: steady, wrap, ripple, timeout,
// ignored-request and mid-HOLD reset scenarios.
module tb_ripple_count_capture;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic       req = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       out_valid;
  logic [3:0] out_cnt;
  logic [3:0] out_delta;
  logic       out_timeout;

  int n_vec = 0;
  int n_err = 0;

  ripple_count_capture #(
    .SIZE    (4),
    .STABLE  (3),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cnt_in      (cnt_in),
    .req         (req),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_cnt     (out_cnt),
    .out_delta   (out_delta),
    .out_timeout (out_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!out_valid && i < 40) begin
      @(negedge clk);
      i++;
    end
    check_val({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check_val({tag, "_drop"}, out_valid, 0);
    check_val({tag, "_idle"}, busy, 0);
    out_ready = 1'b0;
  endtask

  task automatic capture_steady(input logic [3:0] v, input string tag, input logic [3:0] exp_delta);
    cnt_in = v;
    step(6);
    req = 1'b1;
    step(1);
    req = 1'b0;
    wait_valid(tag);
    check_val({tag, "_cnt"}, out_cnt, v);
    check_val({tag, "_delta"}, out_delta, exp_delta);
    check_val({tag, "_tmo"}, out_timeout, 0);
    accept(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_t;
    logic [3:0] exp_d;
    logic [3:0] seen;
    int         pulses;

    // Reset with a nonzero counter input.
    cnt_in = 4'hA;
    #1 rstn = 1'b0;
    step(2);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_cnt", out_cnt, 0);
    check_val("rst_delta", out_delta, 0);
    check_val("rst_tmo", out_timeout, 0);
    rstn = 1'b1;
    step(1);
    check_val("post_rst_busy", busy, 0);

    // Steady value: minimum latency, then frozen outputs while not ready.
    cnt_in = 4'd5;
    step(6);
    req = 1'b1;
    step(1);
    req = 1'b0;
    check_val("lat_settle_valid", out_valid, 0);
    check_val("lat_settle_busy", busy, 1);
    step(1);
    check_val("steady_valid", out_valid, 1);
    check_val("steady_cnt", out_cnt, 5);
    check_val("steady_delta", out_delta, 5);
    check_val("steady_tmo", out_timeout, 0);
    cnt_in = 4'd0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_val("freeze_valid", out_valid, 1);
      check_val("freeze_cnt", out_cnt, 5);
      check_val("freeze_delta", out_delta, 5);
    end
    accept("steady");

    // Wrap-around delta.
    capture_steady(4'd14, "cap14", 4'd9);
    capture_steady(4'd3, "wrap3", 4'd5);

    // Ripple 7 -> 8 through 6, 4, 0 with the request mid-ripple.
    cnt_in = 4'd7;
    step(6);
    cnt_in = 4'd6;
    step(1);
    cnt_in = 4'd4;
    step(1);
    cnt_in = 4'd0;
    req = 1'b1;
    step(1);
    cnt_in = 4'd8;
    req = 1'b0;
    wait_valid("ripple");
    check_val("ripple_cnt", out_cnt, 8);
    check_val("ripple_delta", out_delta, 5);
    check_val("ripple_tmo", out_timeout, 0);
    accept("ripple");

    // Timeout: counter toggles every cycle so it never settles.
    for (int i = 0; i < 4; i++) begin
      cnt_in = (cnt_in == 4'd1) ? 4'd2 : 4'd1;
      step(1);
    end
    cnt_in = (cnt_in == 4'd1) ? 4'd2 : 4'd1;
    exp_t = cnt_in;
    exp_d = exp_t - 4'd8;
    req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (i == 1) req = 1'b0;
      if (i == 16) check_val("tmo_early", out_valid, 0);
      else cnt_in = (cnt_in == 4'd1) ? 4'd2 : 4'd1;
    end
    step(1);
    check_val("tmo_valid", out_valid, 1);
    check_val("tmo_flag", out_timeout, 1);
    check_val("tmo_cnt", out_cnt, exp_t);
    check_val("tmo_delta", out_delta, exp_d);
    accept("tmo");

    // Requests held through SETTLE and HOLD yield exactly one snapshot.
    cnt_in = 4'd9;
    step(6);
    out_ready = 1'b1;
    req = 1'b1;
    pulses = 0;
    seen = 4'd0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 3) req = 1'b0;
      if (out_valid) begin
        pulses++;
        seen = out_cnt;
      end
    end
    out_ready = 1'b0;
    check_val("ign_pulses", pulses, 1);
    check_val("ign_cnt", seen, 9);

    // Reset during HOLD discards the snapshot and clears last_cnt.
    cnt_in = 4'd12;
    step(6);
    req = 1'b1;
    step(1);
    req = 1'b0;
    wait_valid("hold_rst");
    #2 rstn = 1'b0;
    #1;
    check_val("hold_rst_valid", out_valid, 0);
    check_val("hold_rst_busy", busy, 0);
    check_val("hold_rst_cnt", out_cnt, 0);
    check_val("hold_rst_delta", out_delta, 0);
    step(2);
    rstn = 1'b1;
    capture_steady(4'd5, "post_rst5", 4'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
